// File: rtl/quadrature_encode.sv
// Quadrature step generator: walks a registered position toward a latched target,
// one count per prescaled step, emitting Gray-coded A/B phases straight from flops.
module quadrature_encode #(
    parameter int width     = 8,
    parameter int div_width = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [width-1:0]     target,
    input  logic [div_width-1:0] divisor,
    output logic                 A,
    output logic                 B,
    output logic [width-1:0]     position,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t               state_q, state_d;
    logic [width-1:0]     position_q, position_d;
    logic [width-1:0]     target_q, target_d;
    logic [div_width-1:0] div_q, div_d;
    logic [div_width-1:0] presc_q, presc_d;
    logic                 a_q, a_d;
    logic                 b_q, b_d;
    logic                 done_q, done_d;
    logic [width-1:0]     diff;
    logic                 at_target;

    // NOTE: every variable gets a default first so no path through this block infers a latch.
    always_comb begin
        state_d    = state_q;
        position_d = position_q;
        target_d   = target_q;
        div_d      = div_q;
        presc_d    = presc_q;
        done_d     = 1'b0;
        diff       = target_q - position_q;

        // A load replaces the command but only an idle load restarts the prescaler.
        if (load) begin
            target_d = target;
            div_d    = divisor;
            if (state_q == IDLE) presc_d = divisor;
        end

        // A due step still heads toward the old target; the new one applies afterwards.
        if (state_q == RUN) begin
            if (presc_q == '0) begin
                if (diff != '0)
                    position_d = diff[width-1] ? position_q - width'(1) : position_q + width'(1);
                presc_d = div_d;
            end else begin
                presc_d = presc_q - div_width'(1);
            end
        end

        at_target = (position_d == target_d);

        case (state_q)
            IDLE: begin
                if (load) begin
                    if (at_target) done_d  = 1'b1;
                    else           state_d = RUN;
                end
            end
            RUN: begin
                if (at_target) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        a_d = position_d[1];
        b_d = position_d[1] ^ position_d[0];
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from the same pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            position_q <= '0;
            target_q   <= '0;
            div_q      <= '0;
            presc_q    <= '0;
            a_q        <= 1'b0;
            b_q        <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            position_q <= position_d;
            target_q   <= target_d;
            div_q      <= div_d;
            presc_q    <= presc_d;
            a_q        <= a_d;
            b_q        <= b_d;
            done_q     <= done_d;
        end
    end

    assign A        = a_q;
    assign B        = b_q;
    assign position = position_q;
    assign busy     = (state_q == RUN);
    assign done     = done_q;

endmodule

// File: tb/tb_quadrature_encode.sv
// Directed bench for quadrature_encode: hand-computed step timing, direction, reset
// behaviour, and a behavioural quadrature decoder counting the A/B outputs.
module tb_quadrature_encode;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic [7:0]  target = '0;
    logic [15:0] divisor = '0;
    logic        A, B, busy, done;
    logic [7:0]  position;

    int n_checks = 0;
    int n_fail   = 0;

    quadrature_encode #(.width(8), .div_width(16)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .target(target), .divisor(divisor),
        .A(A), .B(B), .position(position), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Independent decoder: three-stage synchroniser, count from phase deltas.
    logic [1:0] s1, s2, s3;
    logic [7:0] dec_cnt;
    logic [1:0] ph_new, ph_old, ph_delta;
    always_comb begin
        ph_new   = {s2[1], s2[1] ^ s2[0]};
        ph_old   = {s3[1], s3[1] ^ s3[0]};
        ph_delta = ph_new - ph_old;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= '0; s2 <= '0; s3 <= '0; dec_cnt <= '0;
        end else begin
            s1 <= {A, B};
            s2 <= s1;
            s3 <= s2;
            if (ph_delta == 2'd1)      dec_cnt <= dec_cnt + 8'd1;
            else if (ph_delta == 2'd3) dec_cnt <= dec_cnt - 8'd1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [7:0] t, input logic [15:0] d);
        load = 1'b1; target = t; divisor = d;
        tick();
        load = 1'b0;
    endtask

    task automatic wait_done(input int max_cycles);
        int n = 0;
        while (done !== 1'b1 && n < max_cycles) begin
            tick();
            n++;
        end
        check("wait_done", {31'd0, done}, 32'd1);
    endtask

    task automatic check_ab(input string tag, input logic [1:0] exp);
        check(tag, {30'd0, A, B}, {30'd0, exp});
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, observed running expected finished");
        $fatal(1);
    end

    initial begin
        logic [7:0] exp_pos;
        logic [7:0] t;
        logic [15:0] d;
        int bad;
        int saw255;

        // Reset state
        #12;
        check("rst_pos", position, 0);
        check_ab("rst_ab", 2'b00);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Up move, divisor 0, load accepted on first edge after release
        do_load(8'd4, 16'd0);
        check("up_load_busy", busy, 1);
        check("up_load_pos", position, 0);
        tick(); check_ab("up_ab1", 2'b01); check("up_pos1", position, 1); check("up_busy1", busy, 1);
        tick(); check_ab("up_ab2", 2'b11); check("up_pos2", position, 2);
        tick(); check_ab("up_ab3", 2'b10); check("up_pos3", position, 3); check("up_done3", done, 0);
        tick(); check_ab("up_ab4", 2'b00); check("up_pos4", position, 4);
        check("up_busy4", busy, 0); check("up_done4", done, 1);
        tick(); check("up_done_once", done, 0);

        // Load equal to position while idle
        do_load(8'd4, 16'd5);
        check("same_busy", busy, 0); check("same_done", done, 1);
        check("same_pos", position, 4); check_ab("same_ab", 2'b00);
        tick(); check("same_done_once", done, 0); check("same_pos2", position, 4);

        // Back to 0, then wrap down to 255 with divisor 2
        do_load(8'd0, 16'd0);
        wait_done(10);
        check("home_pos", position, 0);
        do_load(8'd255, 16'd2);
        check("wrap_busy", busy, 1);
        tick(); tick();
        check("wrap_wait_pos", position, 0);
        tick();
        check("wrap_pos", position, 255); check_ab("wrap_ab", 2'b10);
        check("wrap_busy_end", busy, 0); check("wrap_done", done, 1);

        // Half-range target steps down through 255
        do_load(8'd0, 16'd0);
        wait_done(5);
        check("home2_pos", position, 0);
        do_load(8'd128, 16'd0);
        exp_pos = 8'd0; bad = 0; saw255 = 0;
        for (int i = 0; i < 128; i++) begin
            tick();
            exp_pos = exp_pos - 8'd1;
            if (position !== exp_pos) bad++;
            if (position === 8'd255) saw255 = 1;
        end
        check("half_track_err", bad, 0);
        check("half_saw255", saw255, 1);
        check("half_pos", position, 128);
        check("half_done", done, 1);

        // Retarget mid-move without prescaler restart
        do_load(8'd0, 16'd0);
        wait_done(200);
        check("home3_pos", position, 0);
        do_load(8'd10, 16'd3);
        repeat (3) tick();
        check("rt_wait_pos", position, 0);
        tick(); check("rt_step1", position, 1);
        repeat (4) tick(); check("rt_step2", position, 2);
        do_load(8'd0, 16'd3);
        check("rt_load_pos", position, 2); check("rt_load_busy", busy, 1);
        repeat (3) tick();
        check("rt_step3", position, 1); check_ab("rt_ab3", 2'b01); check("rt_done3", done, 0);
        repeat (4) tick();
        check("rt_pos_end", position, 0); check("rt_done", done, 1); check("rt_busy_end", busy, 0);
        tick(); check("rt_done_once", done, 0);

        // Load of the current position while running stops the move
        do_load(8'd5, 16'd3);
        repeat (4) tick();
        check("stop_pos1", position, 1);
        do_load(8'd1, 16'd3);
        check("stop_busy", busy, 0); check("stop_done", done, 1);
        repeat (5) tick();
        check("stop_pos_hold", position, 1); check("stop_done_once", done, 0);

        // Load coinciding with a due step: step toward old target, then compare new
        do_load(8'd5, 16'd0);
        tick(); check("coin_pos2", position, 2);
        do_load(8'd3, 16'd0);
        check("coin_pos3", position, 3); check("coin_busy", busy, 0); check("coin_done", done, 1);

        // Asynchronous reset mid-move at position 3
        do_load(8'd0, 16'd0);
        wait_done(10);
        do_load(8'd10, 16'd1);
        repeat (6) tick();
        check("mid_pos3", position, 3); check_ab("mid_ab3", 2'b10); check("mid_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_pos", position, 0); check_ab("arst_ab", 2'b00);
        check("arst_busy", busy, 0); check("arst_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) tick();
        check("post_rst_pos", position, 0); check("post_rst_busy", busy, 0);

        // Decoder loopback over random moves
        for (int k = 0; k < 6; k++) begin
            t = 8'($urandom_range(0, 255));
            d = 16'($urandom_range(3, 5));
            do_load(t, d);
            wait_done(1000);
            repeat (4) tick();
            check("loop_pos", position, t);
            check("loop_dec", dec_cnt, position);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
